// File: rtl/mpeg2_stream_packer.sv
// rtl/mpeg2_stream_packer.sv - 256-bit word FIFO re-serialised MSB-first to an OW-bit valid/ready stream
// Optional saturating drop counter: define MPEG2_PACKER_DROPCNT_EN.
module mpeg2_stream_packer #(
    parameter int OW      = 32,
    parameter int DEPTH_L = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_last,
    input  logic [255:0]       i_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [OW-1:0]      o_data,
    output logic               o_last,
    output logic [DEPTH_L:0]   o_level,
    output logic               o_overflow,
    output logic [15:0]        o_drop_cnt
);
    localparam int NB    = 256 / OW;
    localparam int DEPTH = 1 << DEPTH_L;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

    logic [256:0]         mem [DEPTH];
    logic [DEPTH_L-1:0]   wr_ptr;
    logic [DEPTH_L-1:0]   rd_ptr;
    logic [DEPTH_L:0]     count;
    logic [BW-1:0]        b;
    logic [256:0]         head;
    logic [255:0]         shifted;
    logic                 beat_end;
    logic                 xfer;
    logic                 pop;
    logic                 accept;

    assign head     = mem[rd_ptr];
    assign beat_end = (b == BW'(NB - 1));
    assign xfer     = o_valid && o_ready;
    assign pop      = xfer && beat_end;
    // A full FIFO still takes a word when the head's final beat leaves this cycle.
    assign accept   = i_en && (!count[DEPTH_L] || pop);

    // Beat b is selected by shifting it up to the MSB end of the head word.
    assign shifted  = head[255:0] << (OW * int'(b));
    assign o_data   = shifted[255 -: OW];
    assign o_valid  = (count != '0);
    assign o_last   = head[256] && beat_end;
    assign o_level  = count;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {i_last, i_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            b          <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + DEPTH_L'(1);
            end
            if (xfer) begin
                if (beat_end) begin
                    b      <= '0;
                    rd_ptr <= rd_ptr + DEPTH_L'(1);
                end else begin
                    b <= b + BW'(1);
                end
            end
            if (accept && !pop) begin
                count <= count + (DEPTH_L+1)'(1);
            end else if (!accept && pop) begin
                count <= count - (DEPTH_L+1)'(1);
            end
            if (i_en && !accept) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef MPEG2_PACKER_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (i_en && !accept && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mpeg2_stream_packer.sv
// tb/tb_mpeg2_stream_packer.sv - scoreboard bench for mpeg2_stream_packer (OW=32, DEPTH_L=2)
module tb_mpeg2_stream_packer;
    localparam int OW      = 32;
    localparam int DEPTH_L = 2;
    localparam int NB      = 256 / OW;
    localparam int DEPTH   = 1 << DEPTH_L;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_en;
    logic               i_last;
    logic [255:0]       i_data;
    logic               o_valid;
    logic               o_ready;
    logic [OW-1:0]      o_data;
    logic               o_last;
    logic [DEPTH_L:0]   o_level;
    logic               o_overflow;
    logic [15:0]        o_drop_cnt;

    mpeg2_stream_packer #(.OW(OW), .DEPTH_L(DEPTH_L)) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .i_last(i_last), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
        .o_level(o_level), .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: words held, beats already sent of the head word, flags,
    // and the queue of beats the sink must see in order ({last, data}).
    int            mcount = 0;
    int            mbeat  = 0;
    bit            movf   = 0;
    int            mdrop  = 0;
    logic [OW:0]   expq[$];
    bit            mon_on = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef MPEG2_PACKER_DROPCNT_EN
        return mdrop;
`else
        return 0;
`endif
    endfunction

    // Applies the inputs present at the edge just taken to the model.
    task automatic model_edge();
        bit pop_m;
        bit acc;
        logic [255:0] t;
        if (rst) begin
            mcount = 0; mbeat = 0; movf = 0; mdrop = 0;
            expq.delete();
            return;
        end
        pop_m = (mcount > 0) && o_ready && (mbeat == NB - 1);
        acc   = i_en && ((mcount < DEPTH) || pop_m);
        if (mcount > 0 && o_ready) mbeat = (mbeat == NB - 1) ? 0 : mbeat + 1;
        mcount = mcount + int'(acc) - int'(pop_m);
        if (acc) begin
            for (int k = 0; k < NB; k++) begin
                t = i_data >> ((NB - 1 - k) * OW);
                expq.push_back({(i_last && k == NB - 1) ? 1'b1 : 1'b0, t[OW-1:0]});
            end
        end
        if (i_en && !acc) begin
            movf = 1;
            if (mdrop < 65535) mdrop++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    logic          stall_prev = 0;
    logic [OW:0]   held;

    always @(negedge clk) begin
        logic [OW:0] e;
        if (mon_on) begin
            chk("level", o_level, mcount);
            chk("valid", o_valid, mcount != 0);
            chk("overflow", o_overflow, movf);
            chk("drop_cnt", o_drop_cnt, exp_drop());
            if (!rst && stall_prev && o_valid)
                chk("stall_hold", {o_last, o_data}, held);
            if (!rst && o_valid && o_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_extra: got %0h expected no beat", o_data);
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", o_data, e[OW-1:0]);
                    chk("beat_last", o_last, e[OW]);
                end
            end
            stall_prev = !rst && o_valid && !o_ready;
            held = {o_last, o_data};
        end
    end

    task automatic do_reset();
        rst = 1; i_en = 0;
        cyc();
        rst = 0;
    endtask

    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        rst = 1; i_en = 0; i_last = 0; i_data = '0; o_ready = 0;
        cyc();
        mon_on = 1;
        cyc();
        rst = 0;
        cyc();
        chk("reset_level", o_level, 0);
        chk("reset_valid", o_valid, 0);

        // Single word with byte k = k, sink always ready
        for (int k = 0; k < 32; k++) i_data[k*8 +: 8] = 8'(k);
        i_en = 1; i_last = 1; o_ready = 1;
        cyc();
        i_en = 0; i_last = 0;
        chk("latency_valid", o_valid, 1);
        chk("first_beat", o_data, 32'h1F1E1D1C);
        repeat (10) cyc();

        // Backpressure pattern 1,0,0,1,0,0...
        i_data = rnd_word(); i_en = 1; i_last = 1;
        cyc();
        i_en = 0;
        for (int i = 0; i < 30; i++) begin
            o_ready = (i % 3 == 0);
            cyc();
        end

        // Overflow: six words into a four-deep FIFO with the sink stalled
        o_ready = 0;
        for (int i = 0; i < 6; i++) begin
            i_data = rnd_word(); i_last = (i == 3); i_en = 1;
            cyc();
        end
        i_en = 0; i_last = 0;
        chk("ovf_level", o_level, 4);
        chk("ovf_flag", o_overflow, 1);
`ifdef MPEG2_PACKER_DROPCNT_EN
        chk("ovf_drop", o_drop_cnt, 2);
`else
        chk("ovf_drop", o_drop_cnt, 0);
`endif
        o_ready = 1;
        repeat (40) cyc();

        // Full FIFO taking a word in the same cycle as the head's final beat
        do_reset();
        o_ready = 0;
        for (int i = 0; i < 4; i++) begin
            i_data = rnd_word(); i_en = 1;
            cyc();
        end
        i_en = 0;
        o_ready = 1;
        for (int i = 0; i < 20 && mbeat != NB - 1; i++) cyc();
        chk("full_pop_ready", mbeat, NB - 1);
        i_data = rnd_word(); i_en = 1;
        cyc();
        i_en = 0;
        chk("full_pop_level", o_level, 4);
        chk("full_pop_ovf", o_overflow, 0);
        repeat (40) cyc();

        // Reset after beat 3 of a word
        i_data = rnd_word(); i_en = 1;
        cyc();
        i_en = 0;
        repeat (4) cyc();
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_level", o_level, 0);
        chk("rst_mid_ovf", o_overflow, 0);
        i_data = rnd_word(); i_en = 1;
        cyc();
        i_en = 0;
        repeat (10) cyc();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 499) == 0);
            i_en    = ($urandom_range(0, 3) == 0);
            i_last  = $urandom_range(0, 1);
            i_data  = rnd_word();
            o_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst = 0; i_en = 0; o_ready = 1;
        for (int i = 0; i < 200 && mcount != 0; i++) cyc();
        cyc();
        chk("drain_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mpeg2_stream_packer.md
# mpeg2_stream_packer

Parametrised output stage for `mpeg2encoder`. It buffers the encoder's 256-bit `o_en`/`o_last`/`o_data` stream in a word FIFO and re-serialises it to a narrower, backpressured valid/ready stream for byte-oriented sinks such as a DMA, UART bridge or AXI-Stream.

- Byte order matches the `.m2v` file layout: most significant byte first.
- The encoder has no backpressure, so FIFO overflow is detected, flagged and counted here.

## Interface
- `OW`, 32, output width in bits; one of 8, 16, 32, 64, 128, 256.
- `DEPTH_L`, 4, log2 of FIFO depth in 256-bit words (DEPTH = 1<<DEPTH_L).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_en`  in  1  input word strobe (from encoder `o_en`).
- `i_last`  in  1  marks final word of a sequence (from encoder `o_last`).
- `i_data`  in  256  input word; byte 31 = `i_data[255:248]` is first in stream order.
- `o_valid`  out  1  output beat valid.
- `o_ready`  in  1  sink accepts beat.
- `o_data`  out  OW  output beat.
- `o_last`  out  1  final beat of a word tagged `i_last`.
- `o_level`  out  DEPTH_L+1  words held in FIFO, including a partially sent head word.
- `o_overflow`  out  1  sticky; an input word was dropped.
- `o_drop_cnt`  out  16  saturating count of dropped words (see Configuration).

## Operation
- Storage: DEPTH entries of {last, data[255:0]}, write pointer, read pointer, count (DEPTH_L+1 bits), beat index `b` in [0, NB-1], where NB = 256/OW.
- Beat output: `o_data = head.data[255 - b*OW -: OW]`. `o_valid = (count != 0)`. `o_last = head.last && (b == NB-1)`.
- Handshake: a beat transfers when `o_valid && o_ready`.
  - On transfer, `b` increments.
  - When `b == NB-1`, `b` returns to 0, the read pointer advances and the head word is popped.
  - While `o_valid && !o_ready`, `o_data` and `o_last` hold stable.
- Write acceptance: `accept = i_en && (count < DEPTH || pop)`, where `pop` is the final-beat transfer in the same cycle.
  - On accept, the word is stored at the write pointer and the pointer advances.
  - On `i_en && !accept`, the word is dropped, `o_overflow` sets and `o_drop_cnt` increments.
- Count update: `count += accept - pop`. Simultaneous accept and pop leaves count unchanged.
- Pointer wrap-around: natural modulo DEPTH.
- `o_level = count`.
- Reset values: `o_valid=0`, `o_last=0`, `o_level=0`, `o_overflow=0`, `o_drop_cnt=0`, `b=0`, both pointers 0. `o_data` is don't-care while `o_valid=0`.
- Reset mid-word: the partial head word and all queued words are discarded. The next accepted word starts at beat 0.
- `o_overflow` clears only on `rst`.

## Timing
- Latency: a word accepted at edge n (FIFO empty) gives `o_valid=1` with beat 0 after edge n, i.e. in cycle n+1.
- Throughput: one beat per cycle while `o_ready=1`. With OW=256, one word per cycle sustained, including a full FIFO with a simultaneous pop.
- `o_overflow` and `o_drop_cnt` update at the edge that drops the word.
- `o_valid` deasserts at the edge that pops the last word, unless a write is accepted at the same edge.
- No combinational path from `o_ready` to `o_valid`. `o_data`/`o_last` depend only on registers and memory.

## Configuration
- `MPEG2_PACKER_DROPCNT_EN`
  - Defined: `o_drop_cnt` is a 16-bit counter that saturates at 0xFFFF and clears on `rst`.
  - Undefined: the counter is not built and `o_drop_cnt` is tied to 0.
  - `o_overflow` is present in both builds.

## Test plan
- Single word, OW=32: `i_data = 0x1F1E…0100` with `i_last=1`, `o_ready=1` → 8 beats starting the cycle after `i_en`. Beat 0 = 0x1F1E1D1C, beat 7 = 0x03020100; `o_last=1` only on beat 7; `o_level` goes 1 → 0 after beat 7.
- Backpressure: OW=32, `o_ready` pattern 1,0,0,1,… → `o_data`/`o_last` stable across stalled cycles; all 8 beats delivered in order with none duplicated.
- Overflow: DEPTH_L=2, `o_ready=0`, 6 consecutive `i_en` → `o_level=4`; `o_overflow=1` after the 5th edge; `o_drop_cnt=2` with macro, 0 without. Then `o_ready=1` → words 1–4 emerge intact.
- Full with simultaneous pop: DEPTH_L=2, FIFO full, final beat of head transfers in the same cycle as `i_en` → word accepted, `o_level` stays 4, `o_overflow` stays 0.
- Reset mid-word: OW=32, `rst` asserted after beat 3 of a word → next cycle `o_valid=0`, `o_level=0`, `o_overflow=0`. The next input word emits its own beat 0 first.
- Pass-through: OW=256, 10 back-to-back `i_en` with `o_ready=1` → 10 consecutive valid beats equal to the inputs, each one cycle later; `o_level` never exceeds 1.
